fault_event_arbiter: RTL

FAULT_EVENT_ARBITER -- requirements
Module: fault_event_arbiter

---
 rtl/fault_event_pkg.sv | 39 +++
 rtl/fault_event_fifo.sv | 70 +++++++
 rtl/fault_event_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fault_event_pkg.sv
// Shared definitions for the fault event arbiter: record layout, source id
// of the SEU requester and saturating counter helper.
package fault_event_pkg;

    localparam int SRC_ID_W    = 4;
    localparam int SYS_ERR_W   = 1;
    localparam int PAYLOAD_W   = 64;
    localparam int CNT_W       = 16;
    localparam int PAYLOAD_LSB = 0;
    localparam int TS_LSB      = PAYLOAD_LSB + PAYLOAD_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Record layout, MSB first: {srcId, sysErr, timestamp, payload}.
    function automatic int rec_width(input int ts_w);
        return SRC_ID_W + SYS_ERR_W + ts_w + PAYLOAD_W;
    endfunction

    function automatic int sys_err_lsb(input int ts_w);
        return TS_LSB + ts_w;
    endfunction

    function automatic int src_id_lsb(input int ts_w);
        return TS_LSB + ts_w + SYS_ERR_W;
    endfunction

    // The SEU detector sits directly after the last ECC source.
    function automatic logic [SRC_ID_W-1:0] seu_src_id(input int num_ecc);
        return SRC_ID_W'(num_ecc);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [4:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-4){1'b0}}, inc};
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fault_event_fifo.sv
// First-word-fall-through record FIFO with registered full/empty flags.
// Pushes while full and pops while empty are ignored.
module fault_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push_s, do_pop_s;

    // Pointer, occupancy and flag next-state.
    always_comb begin
        do_push_s = push && !full_q;
        do_pop_s  = pop && !empty_q;
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == (AW+1)'(0));
    end

    // Control state; reset flushes by clearing pointers only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/fault_event_arbiter.sv
// Collects ECC error edges and SEU detector records, arbitrates them round-robin
// into a timestamped event FIFO and keeps saturating event statistics.
module fault_event_arbiter
    import fault_event_pkg::*;
#(
    parameter int NUM_ECC    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_ECC-1:0]      eccStatus,
    input  logic                    seuValid,
    output logic                    seuReady,
    input  logic [63:0]             seuData,
    input  logic                    seuSysError,
    output logic                    evtValid,
    input  logic                    evtReady,
    output logic [TS_WIDTH+68:0]    evtRecord,
    output logic [CNT_W-1:0]        eccCount,
    output logic [CNT_W-1:0]        seuCount,
    output logic [CNT_W-1:0]        dropCount,
    output logic                    overflowSticky
);

    localparam int NREQ    = NUM_ECC + 1;
    localparam int REC_W   = rec_width(TS_WIDTH);
    localparam int SYS_LSB = sys_err_lsb(TS_WIDTH);
    localparam int SRC_LSB = src_id_lsb(TS_WIDTH);
    localparam logic [SRC_ID_W-1:0] SEU_ID = seu_src_id(NUM_ECC);

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [NUM_ECC-1:0]  hist_q, hist_d;
    logic [NUM_ECC-1:0]  pend_q, pend_d;
    logic [SRC_ID_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]    ecc_cnt_q, ecc_cnt_d;
    logic [CNT_W-1:0]    seu_cnt_q, seu_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                ovf_q, ovf_d;

    logic [NREQ-1:0]     req_s;
    logic                hi_vld_s, lo_vld_s, sel_hi_s;
    logic [SRC_ID_W-1:0] hi_id_s, lo_id_s;
    logic                seu_first_s, seu_ready_s;
    logic                grant_vld_s, seu_xfer_s;
    logic [SRC_ID_W-1:0] grant_id_s;
    logic [NUM_ECC-1:0]  grant_ecc_s, rise_s, drop_s;
    logic [4:0]          n_rise_s, n_drop_s;
    logic [REC_W-1:0]    push_rec_s;
    logic                fifo_full_s, fifo_empty_s;

    assign req_s = {seuValid, pend_q};

    // Round-robin: lowest requester at or above the pointer, else lowest overall.
    // SEU wins exactly when no ECC bit is pending in the range the search visits first.
    always_comb begin
        hi_vld_s    = 1'b0;
        hi_id_s     = '0;
        lo_vld_s    = 1'b0;
        lo_id_s     = '0;
        sel_hi_s    = 1'b0;
        seu_first_s = 1'b1;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sel_hi_s = req_s[i] && (i >= int'(ptr_q));
            hi_vld_s = hi_vld_s | sel_hi_s;
            hi_id_s  = sel_hi_s ? SRC_ID_W'(i) : hi_id_s;
            lo_vld_s = lo_vld_s | req_s[i];
            lo_id_s  = req_s[i] ? SRC_ID_W'(i) : lo_id_s;
        end
        for (int i = 0; i < NUM_ECC; i++) begin
            seu_first_s = seu_first_s & ~(pend_q[i] && (i >= int'(ptr_q)));
        end
        grant_vld_s = (hi_vld_s | lo_vld_s) & ~fifo_full_s & ~rst;
        grant_id_s  = hi_vld_s ? hi_id_s : lo_id_s;
        seu_ready_s = ~rst & ~fifo_full_s & seu_first_s;
        seu_xfer_s  = grant_vld_s && (grant_id_s == SEU_ID);
    end

    // Edge detect, pending coalescing and event statistics.
    always_comb begin
        rise_s   = eccStatus & ~hist_q;
        n_rise_s = 5'd0;
        n_drop_s = 5'd0;
        for (int i = 0; i < NUM_ECC; i++) begin
            grant_ecc_s[i] = grant_vld_s && (grant_id_s == SRC_ID_W'(i));
        end
        drop_s = rise_s & pend_q & ~grant_ecc_s;
        pend_d = rise_s | (pend_q & ~grant_ecc_s);
        for (int i = 0; i < NUM_ECC; i++) begin
            n_rise_s = n_rise_s + {4'd0, rise_s[i]};
            n_drop_s = n_drop_s + {4'd0, drop_s[i]};
        end
        hist_d     = eccStatus;
        ts_d       = ts_q + TS_WIDTH'(1);
        ecc_cnt_d  = sat_add(ecc_cnt_q, n_rise_s);
        drop_cnt_d = sat_add(drop_cnt_q, n_drop_s);
        seu_cnt_d  = sat_add(seu_cnt_q, {4'd0, seu_xfer_s});
        ovf_d      = ovf_q | (|drop_s);
        if (!grant_vld_s) begin
            ptr_d = ptr_q;
        end else if (grant_id_s == SEU_ID) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_id_s + 4'd1;
        end
    end

    // Record assembly for the granted requester.
    always_comb begin
        push_rec_s = '0;
        push_rec_s[SRC_LSB +: SRC_ID_W]     = grant_id_s;
        push_rec_s[SYS_LSB]                 = seu_xfer_s & seuSysError;
        push_rec_s[TS_LSB +: TS_WIDTH]      = ts_q;
        push_rec_s[PAYLOAD_LSB +: PAYLOAD_W] = seu_xfer_s ? seuData : 64'h0;
    end

    // Arbiter, edge-detect and statistics state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            hist_q     <= '0;
            pend_q     <= '0;
            ptr_q      <= '0;
            ecc_cnt_q  <= '0;
            seu_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            hist_q     <= hist_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            ecc_cnt_q  <= ecc_cnt_d;
            seu_cnt_q  <= seu_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    fault_event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant_vld_s),
        .wdata (push_rec_s),
        .pop   (evtReady),
        .rdata (evtRecord),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign seuReady       = seu_ready_s;
    assign evtValid       = ~fifo_empty_s;
    assign eccCount       = ecc_cnt_q;
    assign seuCount       = seu_cnt_q;
    assign dropCount      = drop_cnt_q;
    assign overflowSticky = ovf_q;

endmodule
